unimem: RTL and testbench
=========================

# unimem

Unibus memory responder: a block-RAM memory that answers DATI, DATIP, DATO and DATOB cycles from any bus master, including the swlight DMA engine and the CPU. It decodes a window of the 18-bit Unibus address space configured by the ARM processor. The ARM can also read and write words directly through a register-mapped port. It sits beside swlight on the same bus signals and ARM register bus.

## Interface
- AW, default 17: word-address bits of RAM. Size is 2^AW words. Word index is a_in_h[AW:1].
- CLOCK  in  1  system clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLOCK
- armwrite  in  1  ARM register write strobe
- armraddr, armwaddr  in  2  ARM read/write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data, combinational from armraddr
- a_in_h  in  18  Unibus address
- c_in_h  in  2  cycle code: 00 DATI, 01 DATIP, 10 DATO, 11 DATOB
- d_in_h  in  16  Unibus data
- init_in_h  in  1  bus INIT
- msyn_in_h  in  1  master sync
- d_out_h  out  16  read data driven to bus; 0 when not responding
- ssyn_out_h  out  1  slave sync

## Operation
- ARM registers:
  - reg 0, read-only: 32'h554D1004.
  - reg 1: [31] enable, [29:24] limit, [21:16] base. Base and limit are in 4KB units, compared against a_in_h[17:12].
  - reg 2: [31] busy/go, [30] write, [AW-1:0] word address.
  - reg 3: [15:0] data.
  - Other addresses read 32'hDEADBEEF.
- Hit condition: enable, base <= a_in_h[17:12] <= limit, and a_in_h[17:13] != 5'b11111. The I/O page is never decoded.
- Responder FSM states: IDLE, RD, WR, HOLD, ARM, ARMRD.
- IDLE:
  - msyn_in_h & hit & ~ssyn_out_h: latch index and c_in_h. Go to RD if c_in_h[1]=0, else WR.
  - Otherwise, if busy is set, go to ARM.
- RD: RAM read issued. Next edge: d_out_h <= RAM word, ssyn_out_h <= 1, go to HOLD.
- WR: write RAM from d_in_h, sampled at this edge. Byte enables:
  - DATO: both bytes.
  - DATOB: high byte if a_in_h[0]=1, low byte if a_in_h[0]=0.
  - Then ssyn_out_h <= 1, go to HOLD.
- RD/WR with msyn_in_h already low (master aborted): no write, no ssyn, go to IDLE.
- HOLD: on ~msyn_in_h, ssyn_out_h <= 0, d_out_h <= 0, go to IDLE.
- ARM port:
  - An ARM write to reg 2 with [31]=1 while busy=0 sets busy and latches address and write flag.
  - A write to reg 2 while busy=1 is ignored. A write to reg 3 while busy=1 is ignored.
  - ARM state: perform the write (full word from reg 3) or issue the read.
  - ARMRD: for a read, capture the RAM word into reg 3. Clear busy, go to IDLE.
- Priority: a Unibus hit in IDLE beats a pending ARM request in the same cycle. The ARM request waits for the next IDLE.
- DATIP is treated as DATI. No read-modify-write lock is required.
- init_in_h:
  - Forces FSM to IDLE, ssyn_out_h=0, d_out_h=0.
  - Clears busy. The ARM operation is discarded and RAM is not written.
  - Config and RAM contents are kept.
- RESET: as init_in_h, plus enable=0, base=0, limit=0, reg 2 address=0, reg 3 data=0. RAM is not cleared.

## Timing
- Reset values: d_out_h=0, ssyn_out_h=0, FSM=IDLE, busy=0.
- DATI: msyn_in_h sampled high at edge T0 (state enters RD). d_out_h and ssyn_out_h are high after edge T1, 2 edges from msyn.
- DATO/DATOB: RAM written and ssyn_out_h high at edge T1.
- Release: ssyn_out_h and d_out_h drop 1 edge after msyn_in_h is sampled low.
- ARM access: busy clears 2 edges after the go write (ARM → ARMRD → IDLE) when the FSM is idle.
- The master guarantees address/data deskew before msyn, so a_in_h, c_in_h and d_in_h are sampled directly with no extra delay.
- RAM is single-port, synchronous read, 1-cycle latency, and is inferred.

## Structure
- Package unimem_pkg holds:
  - cycle-code constants DATI/DATIP/DATO/DATOB
  - FSM state enum
  - ID constant 32'h554D1004
  - I/O-page prefix 5'b11111
- Sub-module unimem_ram: 2^AW x16 single-port RAM with 2-bit byte-write enable and registered read output.

## Test plan
- Config base=0, limit=7, enable=1. DATO 123456 to 001000, then DATI 001000. Expected: ssyn 2 edges after msyn, d_out_h=123456, and both drop 1 edge after msyn falls.
- DATOB 377 to 001001 over 123456. Expected: DATI returns 177456. Then DATOB 000 to 001000. Expected: DATI returns 177400.
- Access 760000 and 200000 (limit=7). Expected: no ssyn and d_out_h=0 for 10 µs. Repeat with enable=0. Expected: no ssyn.
- ARM write go/write, address 000400, data 052525, issued in the same cycle a Unibus DATI hit starts. Expected: the Unibus is served first, busy clears after it. A later ARM read of 000400 returns 052525.
- Assert init_in_h during HOLD of a DATI. Expected: ssyn and d_out_h are 0 the next edge, FSM is IDLE, and the config is still readable.
- Drop msyn in the cycle the FSM is in WR. Expected: RAM unchanged and no ssyn.

Source files
------------

// File: rtl/unimem_pkg.sv
// Shared constants and types for the unimem Unibus memory responder.
package unimem_pkg;

   localparam logic [1:0]  C_DATI  = 2'b00;
   localparam logic [1:0]  C_DATIP = 2'b01;
   localparam logic [1:0]  C_DATO  = 2'b10;
   localparam logic [1:0]  C_DATOB = 2'b11;

   localparam logic [31:0] UNIMEM_ID = 32'h554D1004;
   localparam logic [4:0]  IO_PAGE   = 5'b11111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_HOLD,
      S_ARM,
      S_ARMRD
   } state_t;

   // page is a_in_h[17:12]; the top 8KB (I/O page) is never claimed.
   function automatic logic window_hit(input logic en, input logic [5:0] base,
                                       input logic [5:0] limit, input logic [5:0] page);
      return en && (page >= base) && (page <= limit) && (page[5:1] != IO_PAGE);
   endfunction

endpackage

// File: rtl/unimem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module unimem_ram #(
   parameter int AW = 17
) (
   input  logic          CLOCK,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [0:(1<<AW)-1];

   always_ff @(posedge CLOCK) begin
      if (we[0]) mem[addr][7:0]  <= wdata[7:0];
      if (we[1]) mem[addr][15:8] <= wdata[15:8];
      rdata <= mem[addr];
   end

endmodule

// File: rtl/unimem.sv
// Unibus memory responder: serves DATI/DATIP/DATO/DATOB in an ARM-configured
// window and gives the ARM a word-wide back door into the same RAM.
module unimem #(
   parameter int AW = 17
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        armwrite,
   input  logic [1:0]  armraddr,
   input  logic [1:0]  armwaddr,
   input  logic [31:0] armwdata,
   output logic [31:0] armrdata,
   input  logic [17:0] a_in_h,
   input  logic [1:0]  c_in_h,
   input  logic [15:0] d_in_h,
   input  logic        init_in_h,
   input  logic        msyn_in_h,
   output logic [15:0] d_out_h,
   output logic        ssyn_out_h
);
   import unimem_pkg::*;

   state_t        state, state_nx;
   logic          enable;
   logic [5:0]    base, limit;
   logic          busy, arm_wr;
   logic [AW-1:0] arm_addr;
   logic [15:0]   arm_data;
   logic [AW-1:0] idx;
   logic [1:0]    cyc;
   logic          odd;
   logic [1:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata, ram_rdata;
   logic          clr, hit, take_bus, go_accept, arm_pending;
   logic          unused;

   assign unused = ^{armwdata, a_in_h};

   assign clr         = RESET | init_in_h;
   assign hit         = window_hit(enable, base, limit, a_in_h[17:12]);
   assign take_bus    = msyn_in_h & hit & ~ssyn_out_h;
   assign go_accept   = armwrite && (armwaddr == 2'd2) && armwdata[31] && !busy;
   // A go strobe counts as pending in its own cycle so an idle FSM starts at once.
   assign arm_pending = busy | go_accept;

   // ARM-visible configuration and mailbox registers
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         enable   <= 1'b0;
         base     <= '0;
         limit    <= '0;
         arm_wr   <= 1'b0;
         arm_addr <= '0;
         arm_data <= '0;
      end else begin
         if (armwrite && armwaddr == 2'd1) begin
            enable <= armwdata[31];
            limit  <= armwdata[29:24];
            base   <= armwdata[21:16];
         end
         if (armwrite && armwaddr == 2'd2 && !busy) begin
            arm_wr   <= armwdata[30];
            arm_addr <= armwdata[AW-1:0];
         end
         if (armwrite && armwaddr == 2'd3 && !busy)
            arm_data <= armwdata[15:0];
         else if (state == S_ARMRD && !arm_wr && !init_in_h)
            arm_data <= ram_rdata;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (clr)
         busy <= 1'b0;
      else if (go_accept)
         busy <= 1'b1;
      else if (state == S_ARMRD)
         busy <= 1'b0;
   end

   always_comb begin
      armrdata = 32'hDEADBEEF;
      case (armraddr)
         2'd0:    armrdata = UNIMEM_ID;
         2'd1:    armrdata = {enable, 1'b0, limit, 2'b00, base, 16'h0000};
         2'd2:    armrdata = {busy, arm_wr, {(30-AW){1'b0}}, arm_addr};
         2'd3:    armrdata = {16'h0000, arm_data};
         default: ;
      endcase
   end

   // Bus cycle capture; address and code are deskewed by the master before msyn.
   always_ff @(posedge CLOCK) begin
      if (state == S_IDLE && take_bus) begin
         idx <= a_in_h[AW:1];
         cyc <= c_in_h;
         odd <= a_in_h[0];
      end
   end

   always_ff @(posedge CLOCK) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (take_bus)
               state_nx = c_in_h[1] ? S_WR : S_RD;
            else if (arm_pending)
               state_nx = S_ARM;
         end
         S_RD, S_WR: state_nx = msyn_in_h ? S_HOLD : S_IDLE;
         S_HOLD:     if (!msyn_in_h) state_nx = S_IDLE;
         S_ARM:      state_nx = S_ARMRD;
         S_ARMRD:    state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // In IDLE the bus address goes straight to the RAM so RD already has data.
   always_comb begin
      ram_addr  = idx;
      ram_we    = 2'b00;
      ram_wdata = d_in_h;
      case (state)
         S_IDLE: ram_addr = a_in_h[AW:1];
         S_WR: begin
            if (msyn_in_h && !clr)
               ram_we = (cyc == C_DATOB) ? (odd ? 2'b10 : 2'b01) : 2'b11;
         end
         S_ARM: begin
            ram_addr = arm_addr;
            if (arm_wr && !clr) begin
               ram_we    = 2'b11;
               ram_wdata = arm_data;
            end
         end
         S_ARMRD: ram_addr = arm_addr;
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (clr) begin
         ssyn_out_h <= 1'b0;
         d_out_h    <= '0;
      end else begin
         case (state)
            S_RD: begin
               if (msyn_in_h) begin
                  ssyn_out_h <= 1'b1;
                  d_out_h    <= ram_rdata;
               end
            end
            S_WR: if (msyn_in_h) ssyn_out_h <= 1'b1;
            S_HOLD: begin
               if (!msyn_in_h) begin
                  ssyn_out_h <= 1'b0;
                  d_out_h    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   unimem_ram #(.AW(AW)) u_ram (
      .CLOCK (CLOCK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_unimem.sv
// Randomized self-checking bench for unimem against a word-array memory model.
module tb_unimem;
   localparam int AW = 17;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        armwrite = 1'b0;
   logic [1:0]  armraddr = 2'd0, armwaddr = 2'd0;
   logic [31:0] armwdata = 32'h0;
   logic [31:0] armrdata;
   logic [17:0] a_in_h = 18'h0;
   logic [1:0]  c_in_h = 2'b00;
   logic [15:0] d_in_h = 16'h0;
   logic        init_in_h = 1'b0;
   logic        msyn_in_h = 1'b0;
   logic [15:0] d_out_h;
   logic        ssyn_out_h;

   int checks = 0;
   int failures = 0;
   logic [15:0] mdl [int];

   always #5 CLOCK = ~CLOCK;

   unimem #(.AW(AW)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
      .armwdata(armwdata), .armrdata(armrdata),
      .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
      .init_in_h(init_in_h), .msyn_in_h(msyn_in_h),
      .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
   );

   // ---------------- drivers and model ----------------
   task automatic arm_write(input logic [1:0] r, input logic [31:0] v);
      @(negedge CLOCK);
      armwrite = 1'b1; armwaddr = r; armwdata = v;
      @(posedge CLOCK); #1;
      armwrite = 1'b0;
   endtask

   task automatic arm_read(input logic [1:0] r, output logic [31:0] v);
      armraddr = r; #1;
      v = armrdata;
   endtask

   task automatic wait_idle(output int n);
      logic [31:0] v;
      n = 0;
      arm_read(2'd2, v);
      while (v[31] && n < 20) begin
         @(posedge CLOCK); #1; n++;
         arm_read(2'd2, v);
      end
   endtask

   task automatic bus_start(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d);
      @(negedge CLOCK);
      a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
   endtask

   task automatic wait_ssyn(output int n);
      n = 0;
      do begin @(posedge CLOCK); #1; n++; end while (!ssyn_out_h && n < 20);
   endtask

   task automatic bus_release(output logic ok);
      @(negedge CLOCK); msyn_in_h = 1'b0;
      @(posedge CLOCK); #1;
      ok = (ssyn_out_h === 1'b0) && (d_out_h === 16'h0);
   endtask

   task automatic bus_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                            output logic [15:0] rd, output int n, output logic rel_ok);
      bus_start(a, c, d);
      wait_ssyn(n);
      rd = d_out_h;
      bus_release(rel_ok);
   endtask

   task automatic no_resp(input logic [17:0] a, input int cyc, output int bad);
      bad = 0;
      bus_start(a, 2'b00, 16'h0);
      repeat (cyc) begin
         @(posedge CLOCK); #1;
         if (ssyn_out_h !== 1'b0 || d_out_h !== 16'h0) bad++;
      end
      @(negedge CLOCK); msyn_in_h = 1'b0;
      @(posedge CLOCK); #1;
   endtask

   // A write cycle replaces the word, or just the byte selected by a[0] for DATOB.
   function automatic void mdl_write(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d);
      int w;
      logic [15:0] old;
      w = int'(a >> 1);
      old = mdl.exists(w) ? mdl[w] : 16'h0;
      if (c == 2'b10)  mdl[w] = d;
      else if (a[0])   mdl[w] = {d[15:8], old[7:0]};
      else             mdl[w] = {old[15:8], d[7:0]};
   endfunction

   function automatic logic [31:0] cfg(input logic en, input int b, input int l);
      return {en, 1'b0, 6'(l), 2'b00, 6'(b), 16'h0000};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset;
      logic [31:0] v;
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK); RESET = 1'b0;
      @(posedge CLOCK); #1;
      checks++; if (ssyn_out_h !== 1'b0) begin failures++; $display("FAIL reset_ssyn got=%b exp=0", ssyn_out_h); end
      checks++; if (d_out_h !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", d_out_h); end
      arm_read(2'd0, v);
      checks++; if (v !== 32'h554D1004) begin failures++; $display("FAIL reset_id got=%h exp=554d1004", v); end
      arm_read(2'd1, v);
      checks++; if ((v & 32'hBF3F0000) !== 32'h0) begin failures++; $display("FAIL reset_cfg got=%h exp=0", v); end
      arm_read(2'd2, v);
      checks++; if ((v & 32'hC001FFFF) !== 32'h0) begin failures++; $display("FAIL reset_reg2 got=%h exp=0", v); end
      arm_read(2'd3, v);
      checks++; if ((v & 32'h0000FFFF) !== 32'h0) begin failures++; $display("FAIL reset_reg3 got=%h exp=0", v); end
   endtask

   task automatic test_basic;
      logic [31:0] v;
      logic [15:0] rd;
      int n;
      logic ok;
      arm_write(2'd1, cfg(1'b1, 0, 7));
      arm_read(2'd1, v);
      checks++; if ((v & 32'hBF3F0000) !== 32'h87000000) begin failures++; $display("FAIL cfg_readback got=%h exp=87000000", v); end
      bus_cycle(18'o001000, 2'b10, 16'o123456, rd, n, ok);
      mdl_write(18'o001000, 2'b10, 16'o123456);
      checks++; if (n !== 2) begin failures++; $display("FAIL dato_latency got=%0d exp=2", n); end
      checks++; if (rd !== 16'h0) begin failures++; $display("FAIL dato_dout got=%h exp=0", rd); end
      bus_cycle(18'o001000, 2'b00, 16'h0, rd, n, ok);
      checks++; if (n !== 2) begin failures++; $display("FAIL dati_latency got=%0d exp=2", n); end
      checks++; if (rd !== 16'o123456) begin failures++; $display("FAIL dati_data got=%o exp=123456", rd); end
      checks++; if (!ok) begin failures++; $display("FAIL dati_release got=%b/%h exp=0/0", ssyn_out_h, d_out_h); end
   endtask

   task automatic test_byte;
      logic [15:0] rd;
      int n;
      logic ok;
      bus_cycle(18'o001001, 2'b11, 16'hFFFF, rd, n, ok);
      mdl_write(18'o001001, 2'b11, 16'hFFFF);
      bus_cycle(18'o001000, 2'b00, 16'h0, rd, n, ok);
      checks++; if (rd !== 16'o177456) begin failures++; $display("FAIL datob_hi got=%o exp=177456", rd); end
      bus_cycle(18'o001000, 2'b11, 16'h0000, rd, n, ok);
      mdl_write(18'o001000, 2'b11, 16'h0000);
      bus_cycle(18'o001000, 2'b01, 16'h0, rd, n, ok);
      checks++; if (rd !== 16'o177400) begin failures++; $display("FAIL datob_lo got=%o exp=177400", rd); end
      checks++; if (rd !== mdl[18'o001000 >> 1]) begin failures++; $display("FAIL datob_model got=%o exp=%o", rd, mdl[18'o001000 >> 1]); end
   endtask

   task automatic test_random;
      int pool [6];
      int i, w, n, m;
      logic [1:0] c;
      logic [15:0] d, rd;
      logic [17:0] a;
      logic ok;
      logic [31:0] v;
      for (int k = 0; k < 6; k++) begin
         pool[k] = int'($urandom_range(0, 32'h3FFF));
         d = 16'($urandom);
         bus_cycle(18'(pool[k] * 2), 2'b10, d, rd, n, ok);
         mdl_write(18'(pool[k] * 2), 2'b10, d);
      end
      for (int k = 0; k < 40; k++) begin
         i = int'($urandom_range(0, 5));
         w = pool[i];
         c = 2'($urandom);
         d = 16'($urandom);
         a = 18'(w * 2) | ((c == 2'b11) ? 18'($urandom_range(0, 1)) : 18'h0);
         bus_cycle(a, c, d, rd, n, ok);
         checks++;
         if (n !== 2 || !ok) begin
            failures++; $display("FAIL rand_handshake k=%0d lat=%0d rel=%b exp lat=2 rel=1", k, n, ok);
         end else if (c[1] == 1'b0 && rd !== mdl[w]) begin
            failures++; $display("FAIL rand_read k=%0d a=%o got=%o exp=%o", k, a, rd, mdl[w]);
         end else if (c[1] == 1'b1 && rd !== 16'h0) begin
            failures++; $display("FAIL rand_write_dout k=%0d got=%h exp=0", k, rd);
         end
         if (c[1]) mdl_write(a, c, d);
         if (k % 8 == 7) begin
            arm_write(2'd2, 32'h80000000 | 32'(w));
            wait_idle(m);
            arm_read(2'd3, v);
            checks++; if (v[15:0] !== mdl[w]) begin failures++; $display("FAIL rand_arm_read w=%o got=%o exp=%o", w, v[15:0], mdl[w]); end
         end
      end
   endtask

   task automatic test_arm_priority;
      logic [31:0] v;
      logic [15:0] exp_old;
      int n;
      logic ok;
      exp_old = mdl[32'o400];
      arm_write(2'd3, 32'o052525);
      @(negedge CLOCK);
      a_in_h = 18'o001000; c_in_h = 2'b00; msyn_in_h = 1'b1;
      armwrite = 1'b1; armwaddr = 2'd2; armwdata = 32'hC0000000 | 32'o400;
      @(posedge CLOCK); #1;
      armwrite = 1'b0;
      arm_read(2'd2, v);
      checks++; if (v[31] !== 1'b1) begin failures++; $display("FAIL prio_busy_set got=%b exp=1", v[31]); end
      n = 1;
      while (!ssyn_out_h && n < 20) begin @(posedge CLOCK); #1; n++; end
      checks++; if (n !== 2) begin failures++; $display("FAIL prio_bus_latency got=%0d exp=2", n); end
      checks++; if (d_out_h !== exp_old) begin failures++; $display("FAIL prio_bus_data got=%o exp=%o", d_out_h, exp_old); end
      bus_release(ok);
      arm_read(2'd2, v);
      checks++; if (v[31] !== 1'b1) begin failures++; $display("FAIL prio_busy_waits got=%b exp=1", v[31]); end
      wait_idle(n);
      arm_read(2'd2, v);
      checks++; if (v[31] !== 1'b0 || n == 0) begin failures++; $display("FAIL prio_busy_clear busy=%b edges=%0d exp busy=0", v[31], n); end
      mdl[32'o400] = 16'o052525;
      arm_write(2'd3, 32'h0);
      arm_write(2'd2, 32'h80000000 | 32'o400);
      wait_idle(n);
      checks++; if (n !== 2) begin failures++; $display("FAIL arm_busy_edges got=%0d exp=2", n); end
      arm_read(2'd3, v);
      checks++; if (v[15:0] !== 16'o052525) begin failures++; $display("FAIL arm_read_data got=%o exp=052525", v[15:0]); end
   endtask

   task automatic test_init;
      logic [31:0] v;
      logic [15:0] rd;
      int n, w;
      logic ok;
      bus_start(18'o001000, 2'b00, 16'h0);
      wait_ssyn(n);
      @(negedge CLOCK); init_in_h = 1'b1;
      @(posedge CLOCK); #1;
      checks++; if (ssyn_out_h !== 1'b0 || d_out_h !== 16'h0) begin failures++; $display("FAIL init_hold got=%b/%h exp=0/0", ssyn_out_h, d_out_h); end
      @(negedge CLOCK); init_in_h = 1'b0; msyn_in_h = 1'b0;
      arm_read(2'd1, v);
      checks++; if ((v & 32'hBF3F0000) !== 32'h87000000) begin failures++; $display("FAIL init_cfg_kept got=%h exp=87000000", v); end
      bus_cycle(18'o001000, 2'b00, 16'h0, rd, n, ok);
      checks++; if (n !== 2 || rd !== mdl[32'o400]) begin failures++; $display("FAIL init_then_dati lat=%0d got=%o exp lat=2 data=%o", n, rd, mdl[32'o400]); end
      // init during an ARM write discards it
      w = 32'o400;
      arm_write(2'd3, 32'h1111);
      arm_write(2'd2, 32'hC0000000 | 32'(w));
      init_in_h = 1'b1;
      @(posedge CLOCK); #1;
      init_in_h = 1'b0;
      arm_read(2'd2, v);
      checks++; if (v[31] !== 1'b0) begin failures++; $display("FAIL init_busy_clear got=%b exp=0", v[31]); end
      bus_cycle(18'(w * 2), 2'b00, 16'h0, rd, n, ok);
      checks++; if (rd !== mdl[w]) begin failures++; $display("FAIL init_arm_discard got=%o exp=%o", rd, mdl[w]); end
   endtask

   task automatic test_abort;
      logic [15:0] rd;
      int n, bad;
      logic ok;
      bad = 0;
      bus_start(18'o001000, 2'b10, 16'o070707);
      @(posedge CLOCK); #1;
      @(negedge CLOCK); msyn_in_h = 1'b0;
      repeat (6) begin
         @(posedge CLOCK); #1;
         if (ssyn_out_h !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL abort_ssyn got=%0d exp=0 cycles", bad); end
      bus_cycle(18'o001000, 2'b00, 16'h0, rd, n, ok);
      checks++; if (rd !== mdl[32'o400]) begin failures++; $display("FAIL abort_ram got=%o exp=%o", rd, mdl[32'o400]); end
   endtask

   task automatic test_window;
      logic [15:0] rd;
      int n, bad;
      logic ok;
      no_resp(18'o760000, 500, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL miss_iopage got=%0d exp=0", bad); end
      no_resp(18'o200000, 500, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL miss_above got=%0d exp=0", bad); end
      arm_write(2'd1, cfg(1'b0, 0, 7));
      no_resp(18'o001000, 50, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL miss_disabled got=%0d exp=0", bad); end
      arm_write(2'd1, cfg(1'b1, 2, 3));
      no_resp(18'h01FFE, 20, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL miss_below_base got=%0d exp=0", bad); end
      no_resp(18'h04000, 20, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL miss_above_limit got=%0d exp=0", bad); end
      bus_cycle(18'h02000, 2'b10, 16'h1234, rd, n, ok);
      checks++; if (n !== 2) begin failures++; $display("FAIL hit_base got=%0d exp=2", n); end
      bus_cycle(18'h03FFE, 2'b10, 16'h5678, rd, n, ok);
      checks++; if (n !== 2) begin failures++; $display("FAIL hit_limit got=%0d exp=2", n); end
      arm_write(2'd1, cfg(1'b1, 0, 63));
      bus_cycle(18'h3DFFE, 2'b10, 16'h9ABC, rd, n, ok);
      mdl_write(18'h3DFFE, 2'b10, 16'h9ABC);
      checks++; if (n !== 2) begin failures++; $display("FAIL hit_below_iopage got=%0d exp=2", n); end
      bus_cycle(18'h3DFFE, 2'b00, 16'h0, rd, n, ok);
      checks++; if (rd !== 16'h9ABC) begin failures++; $display("FAIL read_below_iopage got=%h exp=9abc", rd); end
      no_resp(18'h3E000, 20, bad);
      checks++; if (bad !== 0) begin failures++; $display("FAIL miss_iopage_full got=%0d exp=0", bad); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_byte();
      test_random();
      test_arm_priority();
      test_init();
      test_abort();
      test_window();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
